sar_conv_sequencer: RTL and testbench
=====================================

// Module: sar_conv_sequencer
// PURPOSE
//  Sequencer sitting directly around the 6-bit SAR binary-search FSM. It issues the
//  periodic start pulse and captures each result on end-of-conversion. It averages
//  2**AvgLog2 samples and presents the mean on a valid/ready stream to the next stage.
//  Also flags lost averages (overrun) and conversions that never finish (timeout).
// PARAMETERS
//  Width      6   SAR result width (matches SAR FSM result width)
//  AvgLog2    2   log2 of samples per average (0 = pass-through, one sample per output)
//  PeriodW    8   width of period_i / tick counter
//  TimeoutCyc 16  max cycles in CONV waiting for eoc rising edge
// PORTS
//  clk_i     in   1          single clock, all flops rising edge
//  rst_ni    in   1          synchronous, active-low reset
//  en_i      in   1          run sequencer; low -> IDLE
//  clr_i     in   1          clears sticky ovr_o/err_o (one-cycle pulse)
//  period_i  in   PeriodW    idle cycles between conversions, sampled on WAIT entry
//  start_o   out  1          one-cycle start pulse to SAR FSM start input
//  eoc_i     in   1          SAR end-of-conversion
//  result_i  in   Width      SAR result, valid when eoc_i rises
//  avg_o     out  Width      averaged result, stable while valid_o=1
//  valid_o   out  1          avg_o valid
//  ready_i   in   1          downstream accepts avg_o when valid_o&ready_i
//  ovr_o     out  1          sticky: an average was dropped
//  err_o     out  1          sticky: conversion timeout
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state IDLE. start_o, avg_o, valid_o, ovr_o, err_o,
//   alarm_o = 0. Accumulator, sample count, eoc_q = 0.
//  eoc edge: eoc_q <= eoc_i each cycle; rise = eoc_i & ~eoc_q. Acted on only in CONV.
//  FSM:
//   IDLE : en_i=1 -> WAIT, tick <= max(period_i,1).
//   WAIT : tick decrements; WAIT lasts max(period_i,1) cycles, then -> START.
//   START: start_o=1 for exactly this cycle; -> CONV, timer <= 0.
//   CONV : rise -> acc += result_i, cnt += 1.
//          If cnt was 2**AvgLog2-1 -> DONE, else -> WAIT.
//          timer reaches TimeoutCyc without rise -> err_o<=1, sample dropped, -> WAIT.
//   DONE : avg = acc >> AvgLog2 (truncating). If valid_o=0 or ready_i=1: avg_o<=avg,
//          valid_o<=1. Otherwise avg_o unchanged and ovr_o<=1.
//          acc, cnt <= 0; -> WAIT (reload tick).
//  Accumulator width Width+AvgLog2; cannot overflow.
//  Handshake: valid_o falls the cycle after valid_o&ready_i unless DONE reloads the
//   same cycle (DONE load wins, valid_o stays 1). avg_o never changes while
//   valid_o=1 & ready_i=0.
//  en_i=0 in any state: -> IDLE next edge. acc/cnt cleared, in-flight sample discarded.
//   start_o=0. valid_o/avg_o retained until handshake. eoc during IDLE ignored.
//  clr_i=1: ovr_o, err_o <= 0. A set event in the same cycle wins (flag stays 1).
//  Latency: eoc rise of final sample -> valid_o high 2 cycles later (CONV->DONE->reg).
// CONFIGURATION
//  SAR_SEQ_WINDOW_EN defined: adds inputs win_lo_i, win_hi_i [Width-1:0] and output
//   alarm_o. On each DONE load, alarm_o <= (avg<win_lo_i)|(avg>win_hi_i); reset 0.
//   The window is checked only on loaded averages; dropped ones leave alarm_o unchanged.
//  Undefined: those ports are absent; no window logic is generated.
// TESTING (Width=6, AvgLog2=2, TimeoutCyc=16)
//  en_i=1, period_i=3 -> start_o pulses 1 cycle, consecutive pulses >=3+conv cycles apart.
//  Results 10,11,12,13 with ready_i=1 -> avg_o=11, valid_o 1 cycle, ovr_o=0.
//  ready_i=0, two averages (4x20 then 4x40) -> avg_o stays 20, ovr_o=1. clr_i -> ovr_o=0.
//  No eoc after start -> err_o=1 after 16 cycles, next start_o issued, cnt unchanged.
//  en_i low after 2 samples, then high; 4x8 -> avg_o=8 (old partial sum discarded).
//  Window lo=10 hi=30 (SAR_SEQ_WINDOW_EN): avg 5 -> alarm_o=1; avg 20 -> alarm_o=0.

Source files
------------

// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer: drives the SAR binary-search FSM with periodic start pulses.
// It collects 2**AvgLog2 end-of-conversion results and presents their truncated mean
// on a valid/ready stream. Sticky flags report dropped averages (ovr_o) and
// conversions that time out (err_o).
// Optional feature: define SAR_SEQ_WINDOW_EN to add win_lo_i/win_hi_i and alarm_o.
// With it, every loaded average is checked against the window [win_lo_i, win_hi_i].
module sar_conv_sequencer #(
    parameter int Width      = 6,
    parameter int AvgLog2    = 2,
    parameter int PeriodW    = 8,
    parameter int TimeoutCyc = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [PeriodW-1:0] period_i,
    output logic               start_o,
    input  logic               eoc_i,
    input  logic [Width-1:0]   result_i,
    output logic [Width-1:0]   avg_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               ovr_o,
`ifdef SAR_SEQ_WINDOW_EN
    output logic               err_o,
    input  logic [Width-1:0]   win_lo_i,
    input  logic [Width-1:0]   win_hi_i,
    output logic               alarm_o
`else
    output logic               err_o
`endif
);

    localparam int AccW   = Width + AvgLog2;
    localparam int CntW   = (AvgLog2 > 0) ? AvgLog2 : 1;
    localparam int TimerW = $clog2(TimeoutCyc + 1);

    localparam logic [CntW-1:0]   LastCnt     = CntW'((1 << AvgLog2) - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TimeoutCyc - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_CONV,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [PeriodW-1:0] tick_q;
    logic [TimerW-1:0]  timer_q;
    logic [AccW-1:0]    acc_q;
    logic [CntW-1:0]    cnt_q;
    logic               eoc_q;

    // Control strobes produced by the next-state logic for the datapath.
    logic load_tick, dec_tick, clr_timer, inc_timer;
    logic take_sample, clr_acc, done_evt, timeout_evt;

    logic               rise;
    logic [PeriodW-1:0] period_eff;
    logic [Width-1:0]   avg;
    logic               load_avg;

    assign rise       = eoc_i & ~eoc_q;
    // A zero period still waits one cycle so START never follows CONV back-to-back.
    assign period_eff = (period_i == '0) ? PeriodW'(1) : period_i;
    assign avg        = Width'(acc_q >> AvgLog2);
    // A new average may replace the output only if the old one is gone or leaves now.
    assign load_avg   = done_evt & (~valid_o | ready_i);

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of the order in which always blocks are evaluated.
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and strobe decode; en_i low overrides every state, including DONE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d     = state_q;
        start_o     = 1'b0;
        load_tick   = 1'b0;
        dec_tick    = 1'b0;
        clr_timer   = 1'b0;
        inc_timer   = 1'b0;
        take_sample = 1'b0;
        clr_acc     = 1'b0;
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            clr_acc = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_WAIT;
                    load_tick = 1'b1;
                end
                ST_WAIT: begin
                    if (tick_q <= PeriodW'(1)) state_d = ST_START;
                    else                       dec_tick = 1'b1;
                end
                ST_START: begin
                    start_o   = 1'b1;
                    clr_timer = 1'b1;
                    state_d   = ST_CONV;
                end
                ST_CONV: begin
                    if (rise) begin
                        take_sample = 1'b1;
                        if (cnt_q == LastCnt) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_WAIT;
                            load_tick = 1'b1;
                        end
                    end else if (timer_q == TimeoutLast) begin
                        timeout_evt = 1'b1;
                        state_d     = ST_WAIT;
                        load_tick   = 1'b1;
                    end else begin
                        inc_timer = 1'b1;
                    end
                end
                ST_DONE: begin
                    done_evt  = 1'b1;
                    clr_acc   = 1'b1;
                    state_d   = ST_WAIT;
                    load_tick = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: counters, accumulator, output register and sticky flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            eoc_q   <= 1'b0;
            tick_q  <= '0;
            timer_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_o   <= '0;
            valid_o <= 1'b0;
            ovr_o   <= 1'b0;
            err_o   <= 1'b0;
`ifdef SAR_SEQ_WINDOW_EN
            alarm_o <= 1'b0;
`endif
        end else begin
            eoc_q <= eoc_i;

            if (load_tick)     tick_q <= period_eff;
            else if (dec_tick) tick_q <= tick_q - PeriodW'(1);

            if (clr_timer)      timer_q <= '0;
            else if (inc_timer) timer_q <= timer_q + TimerW'(1);

            if (clr_acc) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (take_sample) begin
                acc_q <= acc_q + AccW'(result_i);
                cnt_q <= cnt_q + CntW'(1);
            end

            // A DONE load wins over a same-cycle handshake, keeping valid_o high.
            if (load_avg) begin
                avg_o   <= avg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            // Set events take priority over clr_i.
            if (done_evt && !load_avg) ovr_o <= 1'b1;
            else if (clr_i)            ovr_o <= 1'b0;

            if (timeout_evt) err_o <= 1'b1;
            else if (clr_i)  err_o <= 1'b0;

`ifdef SAR_SEQ_WINDOW_EN
            if (load_avg) alarm_o <= (avg < win_lo_i) | (avg > win_hi_i);
`endif
        end
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Testbench for sar_conv_sequencer. The bench plays the SAR FSM: on every start_o it
// answers with an eoc pulse after a chosen delay, or stays silent to force a timeout.
// A transaction-level model groups the accepted samples, pushes the expected mean into
// a queue, and predicts when the next start pulse should appear. A separate monitor
// pops the queue on every valid/ready handshake and watches that avg_o holds during
// stalls.
`timescale 1ns/1ps
module tb_sar_conv_sequencer;

    localparam int Width      = 6;
    localparam int AvgLog2    = 2;
    localparam int PeriodW    = 8;
    localparam int TimeoutCyc = 16;
    localparam int NAvg       = 1 << AvgLog2;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               en_i;
    logic               clr_i;
    logic [PeriodW-1:0] period_i;
    logic               start_o;
    logic               eoc_i;
    logic [Width-1:0]   result_i;
    logic [Width-1:0]   avg_o;
    logic               valid_o;
    logic               ready_i;
    logic               ovr_o;
    logic               err_o;
`ifdef SAR_SEQ_WINDOW_EN
    logic [Width-1:0]   win_lo_i;
    logic [Width-1:0]   win_hi_i;
    logic               alarm_o;
`endif

    sar_conv_sequencer #(
        .Width(Width), .AvgLog2(AvgLog2), .PeriodW(PeriodW), .TimeoutCyc(TimeoutCyc)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .period_i (period_i),
        .start_o  (start_o),
        .eoc_i    (eoc_i),
        .result_i (result_i),
        .avg_o    (avg_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .ovr_o    (ovr_o),
`ifdef SAR_SEQ_WINDOW_EN
        .err_o    (err_o),
        .win_lo_i (win_lo_i),
        .win_hi_i (win_hi_i),
        .alarm_o  (alarm_o)
`else
        .err_o    (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int               samples[$];
    logic [Width-1:0] exp_q[$];
    bit               exp_ovr = 1'b0;
    bit               exp_err = 1'b0;
    bit               ready_held = 1'b0;
    int               p_eff = 1;
    int               pred_start = 0;
    bit               pred_valid = 1'b0;
    int               last_rise = 0;

    // Downstream ready control.
    bit rdy_auto = 1'b0;
    bit rdy_val  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: random with a bounded stall, or a fixed level.
    initial begin
        int low_run;
        low_run = 0;
        ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rdy_auto) begin
                if (low_run >= 4 || $urandom_range(1, 0) == 1) begin
                    ready_i = 1'b1;
                    low_run = 0;
                end else begin
                    ready_i = 1'b0;
                    low_run++;
                end
            end else begin
                ready_i = rdy_val;
                low_run = 0;
            end
        end
    end

    // Monitor: scoreboard pop on handshake, hold check during stalls.
    bit               stall_q = 1'b0;
    logic [Width-1:0] stall_avg = '0;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (stall_q) begin
                check("hold_valid", valid_o, 1);
                check("hold_avg", avg_o, stall_avg);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL avg_unexpected: got %0d, expected no output", avg_o);
                end else begin
                    check("avg", avg_o, exp_q.pop_front());
                end
            end
            stall_q   <= valid_o && !ready_i;
            stall_avg <= avg_o;
        end else begin
            stall_q <= 1'b0;
        end
    end

    // Record an accepted sample; returns 1 when it completes an average.
    function automatic bit model_accept(input int res);
        int sum;
        samples.push_back(res);
        if (samples.size() < NAvg) return 1'b0;
        sum = 0;
        foreach (samples[i]) sum += samples[i];
        samples.delete();
        if (ready_held && exp_q.size() > 0) exp_ovr = 1'b1;
        else                                exp_q.push_back(Width'(sum / NAvg));
        return 1'b1;
    endfunction

    task automatic set_period(input int p);
        period_i = PeriodW'(p);
        p_eff    = (p == 0) ? 1 : p;
    endtask

    // Called #1 after a posedge while idle.
    task automatic enable();
        en_i       = 1'b1;
        pred_start = cyc + p_eff + 1;
        pred_valid = 1'b1;
    endtask

    // Let a pending DONE complete, then drop en_i; leaves time #1 after a posedge.
    task automatic pause();
        repeat (3) @(posedge clk_i);
        #1;
        en_i       = 1'b0;
        pred_valid = 1'b0;
        samples.delete();
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_start(output int s, output bit ok);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!start_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("start_seen", start_o, 1);
        ok = start_o;
        s  = cyc;
        if (ok && pred_valid) check("start_time", cyc, pred_start);
    endtask

    // Answer one start pulse: eoc rises in CONV cycle d-1 and stays high h cycles,
    // or never rises when timeout is set.
    task automatic do_conv(input bit timeout, input int d, input int h, input int res);
        int s;
        bit ok;
        bit done;
        wait_start(s, ok);
        if (!ok) return;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("start_width", start_o, 0);
        if (timeout) begin
            repeat (TimeoutCyc) @(posedge clk_i);
            #1;
            exp_err = 1'b1;
            check("err_timeout", err_o, 1);
            pred_start = s + TimeoutCyc + p_eff + 1;
        end else begin
            for (int i = 1; i < d; i++) begin
                @(posedge clk_i);
                #1;
            end
            eoc_i    = 1'b1;
            result_i = Width'(res);
            last_rise = s + d;
            done = model_accept(res);
            pred_start = s + d + p_eff + 1 + (done ? 1 : 0);
            @(posedge clk_i);
            #1;
            if (h > 1) begin
                @(posedge clk_i);
                #1;
            end
            eoc_i    = 1'b0;
            result_i = Width'($urandom_range(63, 0));
        end
        pred_valid = 1'b1;
    endtask

    // Start a conversion, then drop en_i mid-CONV; eoc pulses while idle are ignored.
    task automatic do_abort();
        int s;
        bit ok;
        wait_start(s, ok);
        repeat (2) @(posedge clk_i);
        #1;
        en_i = 1'b0;
        samples.delete();
        @(posedge clk_i);
        #1;
        eoc_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        eoc_i = 1'b0;
        @(posedge clk_i);
        #1;
        enable();
    endtask

    task automatic wait_valid(output int seen);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("valid_seen", valid_o, 1);
        seen = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        int n;
        rst_ni   = 1'b0;
        en_i     = 1'b1;
        clr_i    = 1'b0;
        eoc_i    = 1'b1;
        result_i = 6'd33;
        set_period(3);
`ifdef SAR_SEQ_WINDOW_EN
        win_lo_i = 6'd10;
        win_hi_i = 6'd30;
`endif
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_start", start_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_avg", avg_o, 0);
        check("rst_ovr", ovr_o, 0);
        check("rst_err", err_o, 0);
`ifdef SAR_SEQ_WINDOW_EN
        check("rst_alarm", alarm_o, 0);
`endif
        en_i  = 1'b0;
        eoc_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Basic average 10,11,12,13 -> 11 with ready high.
        rdy_val = 1'b1;
        enable();
        do_conv(0, 2, 1, 10);
        do_conv(0, 5, 2, 11);
        do_conv(0, 1, 1, 12);
        do_conv(0, 3, 1, 13);
        wait_valid(seen);
        check("latency", seen, last_rise + 2);
        @(negedge clk_i);
        check("valid_one_cycle", valid_o, 0);
        check("ovr_basic", ovr_o, 0);
        pause();

        // Overrun: downstream stalled across two averages.
        rdy_val    = 1'b0;
        ready_held = 1'b1;
        @(posedge clk_i);
        #1;
        enable();
        for (int i = 0; i < NAvg; i++) do_conv(0, 2 + i, 1, 20);
        for (int i = 0; i < NAvg; i++) do_conv(0, 4, 2, 40);
        pause();
        @(negedge clk_i);
        check("ovr_set", ovr_o, exp_ovr);
        check("ovr_valid", valid_o, 1);
        check("ovr_avg_kept", avg_o, 20);
        @(posedge clk_i);
        #1;
        clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_i   = 1'b0;
        exp_ovr = 1'b0;
        @(negedge clk_i);
        check("ovr_clr", ovr_o, exp_ovr);
        ready_held = 1'b0;
        rdy_val    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("queue_drained", exp_q.size(), 0);

        // Timeout in the middle of a group leaves the sample count untouched.
        check("err_clear", err_o, 0);
        enable();
        do_conv(0, 3, 1, 4);
        do_conv(1, 0, 0, 0);
        do_conv(0, 2, 1, 8);
        do_conv(0, 6, 2, 12);
        do_conv(0, 1, 1, 16);
        pause();
        check("err_sticky", err_o, 1);
        clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_i   = 1'b0;
        exp_err = 1'b0;
        check("err_clr", err_o, exp_err);

        // Enable drop after two samples discards the partial sum.
        enable();
        do_conv(0, 2, 1, 60);
        do_conv(0, 2, 1, 60);
        do_abort();
        for (int i = 0; i < NAvg; i++) do_conv(0, 3, 1, 8);
        pause();

        // Randomised runs with random periods, delays, results, timeouts and ready.
        for (int r = 0; r < 3; r++) begin
            set_period($urandom_range(5, 0));
            rdy_auto = 1'b1;
            @(posedge clk_i);
            #1;
            enable();
            n = 0;
            while (n < 20 || samples.size() != 0) begin
                if ($urandom_range(9, 0) == 0)
                    do_conv(1, 0, 0, 0);
                else
                    do_conv(0, $urandom_range(14, 1), $urandom_range(2, 1),
                            $urandom_range(63, 0));
                n++;
            end
            pause();
            check("rand_ovr", ovr_o, exp_ovr);
            check("rand_err", err_o, exp_err);
            clr_i = 1'b1;
            @(posedge clk_i);
            #1;
            clr_i   = 1'b0;
            exp_err = 1'b0;
        end
        rdy_auto = 1'b0;
        rdy_val  = 1'b1;

`ifdef SAR_SEQ_WINDOW_EN
        // Window 10..30: mean 5 raises alarm, mean 20 clears it.
        set_period(2);
        @(posedge clk_i);
        #1;
        enable();
        for (int i = 0; i < NAvg; i++) do_conv(0, 2, 1, 5);
        wait_valid(seen);
        @(negedge clk_i);
        check("alarm_low", alarm_o, 1);
        for (int i = 0; i < NAvg; i++) do_conv(0, 2, 1, 20);
        wait_valid(seen);
        @(negedge clk_i);
        check("alarm_inside", alarm_o, 0);
        pause();
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
